// File: rtl/pdp8_pkg.sv
// Shared constants and types for the PDP-8 memory responder.
// Holds the auto-index window, word/address widths and the responder state encoding.
package pdp8_pkg;

  localparam int WORD_W = 12;
  localparam int ADDR_W = 12;

  localparam logic [11:0] AUTOIDX_LO = 12'o0010;
  localparam logic [11:0] AUTOIDX_HI = 12'o0017;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    ACCESS = 3'd2,
    AINC   = 3'd3,
    ACK    = 3'd4
  } state_e;

  // True when a word address falls inside the auto-index window 0o10..0o17.
  function automatic logic is_autoidx(input logic [31:0] a);
    return (a >= 32'(AUTOIDX_LO)) && (a <= 32'(AUTOIDX_HI));
  endfunction

endpackage

// File: rtl/pdp8_mem_array.sv
// Single-port synchronous RAM backing PDP-8 main memory.
// No reset: contents survive rst, and read data is registered on every clock.
module pdp8_mem_array #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pdp8_mem_responder.sv
// Memory-side responder for the PDP-8 multi-cycle memory port.
// Services one request per IDLE visit and performs auto-index increment on indirect fetches.
module pdp8_mem_responder #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 12,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic              ind,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  import pdp8_pkg::*;

  localparam logic [2:0] CNT_INIT = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              ind_q, ind_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  pdp8_mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  // The array is read every cycle at the address of the previous cycle, so the
  // word seen in ACCESS was fetched at the edge that entered ACCESS (the live
  // addr in IDLE equals what gets latched at that same edge).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    ind_d     = ind_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;

    case (state_q)
      IDLE: begin
        ram_addr = addr;
        if (req) begin
          we_d    = we;
          ind_d   = ind;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = CNT_INIT;
          state_d = (LATENCY == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ACCESS: begin
        if (we_q) begin
          ram_we  = 1'b1;
          state_d = ACK;
        end else begin
          rdata_d = ram_rdata;
          if (ind_q && is_autoidx(32'(addr_q))) begin
            state_d = AINC;
          end else begin
            state_d = ACK;
          end
        end
      end
      AINC: begin
        ram_we    = 1'b1;
        ram_wdata = rdata_q + DATA_W'(1);
        rdata_d   = rdata_q + DATA_W'(1);
        state_d   = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      we_q    <= 1'b0;
      ind_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      ind_q   <= ind_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign ack   = (state_q == ACK);
  assign busy  = (state_q != IDLE);
  assign rdata = rdata_q;

endmodule

// File: tb/tb_pdp8_mem_responder.sv
// Scoreboard bench for pdp8_mem_responder at LATENCY 0, 1 and 7.
// Stimulus pushes expected acks; a negedge monitor pops and compares rdata and latency.
module tb_pdp8_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_a   [3];
  logic        we_a    [3];
  logic        ind_a   [3];
  logic        ack_a   [3];
  logic        busy_a  [3];
  logic [11:0] addr_a  [3];
  logic [11:0] wdata_a [3];
  logic [11:0] rdata_a [3];

  typedef struct {
    int          idx;
    logic [11:0] rd;
    int          lat;
    int          issue;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_ack [3];

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 1 : 7);
      pdp8_mem_responder #(
        .ADDR_W (12),
        .DATA_W (12),
        .LATENCY(LAT)
      ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req_a[g]),
        .we   (we_a[g]),
        .ind  (ind_a[g]),
        .addr (addr_a[g]),
        .wdata(wdata_a[g]),
        .ack  (ack_a[g]),
        .rdata(rdata_a[g]),
        .busy (busy_a[g])
      );
    end
  endgenerate

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every ack pops one expectation and checks owner, data, latency and width.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ack_a[i] === 1'b1) begin
        checks++;
        if (prev_ack[i] === 1'b1) begin
          errors++;
          $display("[TB] FAIL ack_width dut=%0d: ack high %0d consecutive cycles, required 1", i, 2);
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_ack dut=%0d: got ack, required none pending", i);
        end else begin
          mon_e = exp_q.pop_front();
          checks++;
          if (mon_e.idx != i) begin
            errors++;
            $display("[TB] FAIL ack_owner: got dut=%0d, required dut=%0d", i, mon_e.idx);
          end
          checks++;
          if (rdata_a[i] !== mon_e.rd) begin
            errors++;
            $display("[TB] FAIL rdata dut=%0d: got %o, required %o", i, rdata_a[i], mon_e.rd);
          end
          checks++;
          if ((cyc - mon_e.issue) != mon_e.lat) begin
            errors++;
            $display("[TB] FAIL latency dut=%0d: got %0d cycles, required %0d", i, cyc - mon_e.issue, mon_e.lat);
          end
        end
      end
      prev_ack[i] = ack_a[i];
    end
  end

  task automatic waitAck(input int idx);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ack_a[idx] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL ack_timeout dut=%0d: got no ack in %0d cycles, required ack", idx, 40);
      exp_q.delete();
    end
  endtask

  task automatic applyStimulus(input int idx, input logic w, input logic i,
                               input logic [11:0] a, input logic [11:0] d,
                               input logic [11:0] exp_rd, input int exp_lat);
    exp_t e;
    @(negedge clk);
    req_a[idx]   = 1'b1;
    we_a[idx]    = w;
    ind_a[idx]   = i;
    addr_a[idx]  = a;
    wdata_a[idx] = d;
    e.idx   = idx;
    e.rd    = exp_rd;
    e.lat   = exp_lat;
    e.issue = cyc;
    exp_q.push_back(e);
    waitAck(idx);
    req_a[idx] = 1'b0;
    we_a[idx]  = 1'b0;
    ind_a[idx] = 1'b0;
  endtask

  task automatic checkOutput(input int idx, input logic exp_ack, input logic exp_busy,
                             input logic [11:0] exp_rd, input string tag);
    checks++;
    if (ack_a[idx] !== exp_ack) begin
      errors++;
      $display("[TB] FAIL %s_ack dut=%0d: got %b, required %b", tag, idx, ack_a[idx], exp_ack);
    end
    checks++;
    if (busy_a[idx] !== exp_busy) begin
      errors++;
      $display("[TB] FAIL %s_busy dut=%0d: got %b, required %b", tag, idx, busy_a[idx], exp_busy);
    end
    checks++;
    if (rdata_a[idx] !== exp_rd) begin
      errors++;
      $display("[TB] FAIL %s_rdata dut=%0d: got %o, required %o", tag, idx, rdata_a[idx], exp_rd);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      req_a[i]    = 1'b0;
      we_a[i]     = 1'b0;
      ind_a[i]    = 1'b0;
      addr_a[i]   = '0;
      wdata_a[i]  = '0;
      prev_ack[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) checkOutput(i, 1'b0, 1'b0, 12'o0000, "reset");
    @(negedge clk);
    rst = 1'b0;

    // LATENCY=0: plain 2 cycles, auto-index 3
    applyStimulus(0, 1'b1, 1'b0, 12'o0100, 12'o0707, 12'o0000, 2);
    applyStimulus(0, 1'b0, 1'b0, 12'o0100, 12'o0000, 12'o0707, 2);
    applyStimulus(0, 1'b1, 1'b0, 12'o0011, 12'o0001, 12'o0707, 2);
    applyStimulus(0, 1'b0, 1'b1, 12'o0011, 12'o0000, 12'o0002, 3);

    // LATENCY=7: plain 9 cycles, auto-index 10
    applyStimulus(2, 1'b1, 1'b0, 12'o0100, 12'o3070, 12'o0000, 9);
    applyStimulus(2, 1'b0, 1'b0, 12'o0100, 12'o0000, 12'o3070, 9);
    applyStimulus(2, 1'b1, 1'b0, 12'o0016, 12'o1000, 12'o3070, 9);
    applyStimulus(2, 1'b0, 1'b1, 12'o0016, 12'o0000, 12'o1001, 10);

    // LATENCY=1: basic write/read, auto-index, wrap and window boundaries
    applyStimulus(1, 1'b1, 1'b0, 12'o0200, 12'o1234, 12'o0000, 3);
    applyStimulus(1, 1'b0, 1'b0, 12'o0200, 12'o0000, 12'o1234, 3);
    applyStimulus(1, 1'b1, 1'b0, 12'o0012, 12'o0377, 12'o1234, 3);
    applyStimulus(1, 1'b0, 1'b1, 12'o0012, 12'o0000, 12'o0400, 4);
    applyStimulus(1, 1'b0, 1'b0, 12'o0012, 12'o0000, 12'o0400, 3);
    applyStimulus(1, 1'b1, 1'b0, 12'o0017, 12'o7777, 12'o0400, 3);
    applyStimulus(1, 1'b0, 1'b1, 12'o0017, 12'o0000, 12'o0000, 4);
    applyStimulus(1, 1'b0, 1'b0, 12'o0017, 12'o0000, 12'o0000, 3);
    applyStimulus(1, 1'b1, 1'b0, 12'o0007, 12'o0111, 12'o0000, 3);
    applyStimulus(1, 1'b0, 1'b1, 12'o0007, 12'o0000, 12'o0111, 3);
    applyStimulus(1, 1'b0, 1'b0, 12'o0007, 12'o0000, 12'o0111, 3);
    applyStimulus(1, 1'b1, 1'b0, 12'o0020, 12'o0222, 12'o0111, 3);
    applyStimulus(1, 1'b0, 1'b1, 12'o0020, 12'o0000, 12'o0222, 3);
    applyStimulus(1, 1'b0, 1'b0, 12'o0020, 12'o0000, 12'o0222, 3);
    applyStimulus(1, 1'b1, 1'b1, 12'o0010, 12'o0500, 12'o0222, 3);
    applyStimulus(1, 1'b0, 1'b0, 12'o0010, 12'o0000, 12'o0500, 3);
    applyStimulus(1, 1'b0, 1'b1, 12'o0010, 12'o0000, 12'o0501, 4);
    applyStimulus(1, 1'b1, 1'b0, 12'o0400, 12'o1111, 12'o0501, 3);
    applyStimulus(1, 1'b1, 1'b0, 12'o0401, 12'o2222, 12'o0501, 3);

    // Held req with addr changed while busy: latched 0o400 first, then 0o401 from the next IDLE
    @(negedge clk);
    req_a[1]  = 1'b1;
    we_a[1]   = 1'b0;
    ind_a[1]  = 1'b0;
    addr_a[1] = 12'o0400;
    e.idx = 1; e.rd = 12'o1111; e.lat = 3; e.issue = cyc;
    exp_q.push_back(e);
    e.rd = 12'o2222; e.lat = 7;
    exp_q.push_back(e);
    @(negedge clk);
    addr_a[1] = 12'o0401;
    waitAck(1);
    waitAck(1);
    req_a[1] = 1'b0;

    // Reset during WAIT of a write: aborted, old word kept
    applyStimulus(1, 1'b1, 1'b0, 12'o0300, 12'o0055, 12'o2222, 3);
    @(negedge clk);
    req_a[1]   = 1'b1;
    we_a[1]    = 1'b1;
    addr_a[1]  = 12'o0300;
    wdata_a[1] = 12'o7777;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 checkOutput(1, 1'b0, 1'b0, 12'o0000, "rst_midop");
    @(negedge clk);
    req_a[1] = 1'b0;
    we_a[1]  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 1'b0, 1'b0, 12'o0300, 12'o0000, 12'o0055, 3);
    applyStimulus(1, 1'b0, 1'b0, 12'o0200, 12'o0000, 12'o1234, 3);

    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending_acks: got %0d outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
